mem_accum_sequencer: RTL

MEM_ACCUM_SEQUENCER -- requirements
Module: mem_accum_sequencer

---
 rtl/mem_accum_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_accum_sequencer.sv
// Single-job memory accumulator: streams a word range from a synchronous-read RAM,
// adds or subtracts it into an accumulator, and writes the sum back to a destination word.
module mem_accum_sequencer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_pulse,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              op_sub,
    output logic              busy,
    output logic              done_pulse,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, DRAIN, WB, DONE} state_t;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W+1:0] DEPTH_W = DEPTH[ADDR_W+1:0];

    state_t            state, state_d;
    logic [ADDR_W-1:0] base_q, dst_q;
    logic [ADDR_W:0]   len_q, rd_cnt;
    logic              op_q;
    logic              rd_vld;
    logic [DATA_W-1:0] acc;
    logic [ADDR_W+1:0] span;
    logic              range_bad;
    logic              last_rd;

    // Range is legal when the last source word still fits below DEPTH.
    assign span      = {2'b00, base_addr} + {1'b0, length};
    assign range_bad = span > DEPTH_W;
    assign last_rd   = rd_cnt == (len_q - (ADDR_W+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = state;
        busy       = (state != IDLE);
        done_pulse = (state == DONE);
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        case (state)
            IDLE: begin
                if (start_pulse) begin
                    if (range_bad)        state_d = DONE;
                    else if (length == '0) state_d = WB;
                    else                  state_d = RD;
                end
            end
            RD: begin
                mem_addr = base_q + rd_cnt[ADDR_W-1:0];
                if (last_rd) state_d = DRAIN;
            end
            DRAIN: state_d = WB;
            WB: begin
                mem_addr  = dst_q;
                mem_wdata = acc;
                mem_we    = 1'b1;
                mem_be    = 4'b1111;
                state_d   = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rd_vld trails RD by one cycle, lining up with the RAM's read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            op_q   <= 1'b0;
            rd_cnt <= '0;
            rd_vld <= 1'b0;
            acc    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            rd_vld <= (state == RD);
            if (rd_vld) acc <= op_q ? (acc - mem_rdata) : (acc + mem_rdata);
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        base_q <= base_addr;
                        len_q  <= length;
                        dst_q  <= dst_addr;
                        op_q   <= op_sub;
                        rd_cnt <= '0;
                        acc    <= '0;
                        err    <= range_bad;
                    end
                end
                RD:      rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
                WB:      result <= acc;
                default: ;
            endcase
        end
    end

endmodule
